// File: rtl/cfg_frame_loader.sv
// Configuration frame loader: streams a frame into a shadow register,
// verifies an XOR checksum and gates the routing latches on a good frame.
module cfg_frame_loader #(
  parameter int WORD_W       = 8,
  parameter int FRAME_BITS   = 64,
  parameter int LATCH_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic [WORD_W-1:0]     IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [FRAME_BITS-1:0] CFG_OUT,
  output logic                  LATCH_G,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int NWORDS = FRAME_BITS / WORD_W;
  localparam int CW     = $clog2(NWORDS + 1);
  localparam int LW     = $clog2(LATCH_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(NWORDS);
  localparam logic [LW-1:0] LC   = LW'(LATCH_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [WORD_W-1:0]     acc;
  logic [LW-1:0]         ccnt;
  logic                  rst_commit;
  logic [FRAME_BITS-1:0] shadow;
  logic                  done;
  logic                  err;
  logic                  xfer;

  assign xfer = IN_VALID && !ABORT;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      // Reset runs a commit of the cleared shadow so every latch reads 0.
      state      <= COMMIT;
      ccnt       <= LC;
      rst_commit <= 1'b1;
      shadow     <= '0;
      cnt        <= '0;
      acc        <= '0;
      err        <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            state <= LOAD;
            cnt   <= '0;
            acc   <= '0;
            err   <= 1'b0;
          end
        end
        LOAD: begin
          if (ABORT) begin
            state <= IDLE;
          end else if (xfer && cnt < LAST) begin
            shadow <= {IN_DATA, shadow[FRAME_BITS-1:WORD_W]};
            acc    <= acc ^ IN_DATA;
            cnt    <= cnt + 1'b1;
          end else if (xfer) begin
            if (IN_DATA == acc) begin
              state      <= COMMIT;
              ccnt       <= LC;
              rst_commit <= 1'b0;
            end else begin
              state <= IDLE;
              err   <= 1'b1;
            end
          end
        end
        COMMIT: begin
          if (ccnt <= LW'(1)) begin
            state      <= IDLE;
            done       <= !rst_commit;
            rst_commit <= 1'b0;
          end else begin
            ccnt <= ccnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign IN_READY = (state == LOAD);
  assign LATCH_G  = (state != COMMIT);
  assign BUSY     = (state != IDLE);
  assign DONE     = done;
  assign ERR      = err;
  assign CFG_OUT  = shadow;

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Directed bench for cfg_frame_loader with WORD_W=8, FRAME_BITS=32,
// LATCH_CYCLES=2.
module tb_cfg_frame_loader;

  logic        CLK = 1'b0;
  logic        RESET, START, ABORT, IN_VALID;
  logic [7:0]  IN_DATA;
  logic        IN_READY, LATCH_G, BUSY, DONE, ERR;
  logic [31:0] CFG_OUT;

  int checks = 0;
  int failures = 0;

  cfg_frame_loader #(
    .WORD_W(8),
    .FRAME_BITS(32),
    .LATCH_CYCLES(2)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .START(START),
    .ABORT(ABORT),
    .IN_DATA(IN_DATA),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .CFG_OUT(CFG_OUT),
    .LATCH_G(LATCH_G),
    .BUSY(BUSY),
    .DONE(DONE),
    .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] w);
    IN_DATA  = w;
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
  endtask

  task automatic start_frame();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; ABORT = 1'b0;
    IN_VALID = 1'b0; IN_DATA = 8'h00;

    // Power-on reset commit
    step(); step(); step();
    chk("rst_cfg", CFG_OUT, 32'h0);
    chk("rst_latch", {31'b0, LATCH_G}, 32'd0);
    chk("rst_busy", {31'b0, BUSY}, 32'd1);
    RESET = 1'b0;
    chk("rstc1_latch", {31'b0, LATCH_G}, 32'd0);
    step();
    chk("rstc2_latch", {31'b0, LATCH_G}, 32'd0);
    step();
    chk("rst_end_latch", {31'b0, LATCH_G}, 32'd1);
    chk("rst_end_busy", {31'b0, BUSY}, 32'd0);
    chk("rst_end_done", {31'b0, DONE}, 32'd0);
    chk("rst_end_err", {31'b0, ERR}, 32'd0);

    // Good frame, with an ABORT during commit that must be ignored
    start_frame();
    chk("good_ready", {31'b0, IN_READY}, 32'd1);
    chk("good_busy", {31'b0, BUSY}, 32'd1);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h44);
    chk("good_latch1", {31'b0, LATCH_G}, 32'd0);
    chk("good_cfg", CFG_OUT, 32'h44332211);
    chk("good_ready_c", {31'b0, IN_READY}, 32'd0);
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    chk("good_latch2", {31'b0, LATCH_G}, 32'd0);
    chk("good_done_early", {31'b0, DONE}, 32'd0);
    step();
    chk("good_latch3", {31'b0, LATCH_G}, 32'd1);
    chk("good_done", {31'b0, DONE}, 32'd1);
    chk("good_busy_end", {31'b0, BUSY}, 32'd0);
    chk("good_err", {31'b0, ERR}, 32'd0);
    step();
    chk("good_done_pulse", {31'b0, DONE}, 32'd0);

    // Bad checksum
    start_frame();
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h45);
    chk("bad_err", {31'b0, ERR}, 32'd1);
    chk("bad_busy", {31'b0, BUSY}, 32'd0);
    chk("bad_latch", {31'b0, LATCH_G}, 32'd1);
    chk("bad_ready", {31'b0, IN_READY}, 32'd0);
    chk("bad_done", {31'b0, DONE}, 32'd0);
    step();
    chk("bad_latch2", {31'b0, LATCH_G}, 32'd1);
    chk("bad_done2", {31'b0, DONE}, 32'd0);
    chk("bad_err_sticky", {31'b0, ERR}, 32'd1);

    // Word offered in IDLE is not accepted
    IN_DATA = 8'h99; IN_VALID = 1'b1;
    chk("idle_ready", {31'b0, IN_READY}, 32'd0);
    step();
    IN_VALID = 1'b0;
    chk("idle_cfg", CFG_OUT, 32'h44332211);

    // Bubbles, START during LOAD ignored
    start_frame();
    chk("restart_err", {31'b0, ERR}, 32'd0);
    send(8'h11); step();
    START = 1'b1;
    send(8'h22);
    START = 1'b0;
    step();
    chk("bub_mid_cfg", CFG_OUT, 32'h22114433);
    send(8'h33); step();
    send(8'h44); step();
    chk("bub_wait_busy", {31'b0, BUSY}, 32'd1);
    send(8'h44);
    chk("bub_latch1", {31'b0, LATCH_G}, 32'd0);
    chk("bub_cfg", CFG_OUT, 32'h44332211);
    step();
    chk("bub_latch2", {31'b0, LATCH_G}, 32'd0);
    step();
    chk("bub_done", {31'b0, DONE}, 32'd1);
    chk("bub_latch3", {31'b0, LATCH_G}, 32'd1);

    // Abort after two words; the concurrent word is dropped
    start_frame();
    send(8'hAA); send(8'hBB);
    ABORT = 1'b1;
    send(8'hCC);
    ABORT = 1'b0;
    chk("ab_busy", {31'b0, BUSY}, 32'd0);
    chk("ab_cfg", CFG_OUT, 32'hBBAA4433);
    chk("ab_done", {31'b0, DONE}, 32'd0);
    chk("ab_err", {31'b0, ERR}, 32'd0);
    chk("ab_latch", {31'b0, LATCH_G}, 32'd1);
    step();
    chk("ab_done2", {31'b0, DONE}, 32'd0);
    chk("ab_latch2", {31'b0, LATCH_G}, 32'd1);

    start_frame();
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    send(8'h00);
    chk("ab2_latch1", {31'b0, LATCH_G}, 32'd0);
    chk("ab2_cfg", CFG_OUT, 32'hDDCCBBAA);
    step(); step();
    chk("ab2_done", {31'b0, DONE}, 32'd1);

    // Reset during LOAD
    start_frame();
    send(8'h01); send(8'h02); send(8'h03);
    RESET = 1'b1;
    step();
    chk("rl_cfg", CFG_OUT, 32'h0);
    chk("rl_latch", {31'b0, LATCH_G}, 32'd0);
    RESET = 1'b0;
    step();
    chk("rl_latch2", {31'b0, LATCH_G}, 32'd0);
    step();
    chk("rl_latch3", {31'b0, LATCH_G}, 32'd1);
    chk("rl_done", {31'b0, DONE}, 32'd0);
    chk("rl_busy", {31'b0, BUSY}, 32'd0);

    // Reset during commit cycle 1
    start_frame();
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    send(8'h0C);
    chk("rc_latch1", {31'b0, LATCH_G}, 32'd0);
    chk("rc_cfg_pre", CFG_OUT, 32'h08070605);
    RESET = 1'b1;
    step();
    chk("rc_cfg", CFG_OUT, 32'h0);
    RESET = 1'b0;
    step();
    chk("rc_latch2", {31'b0, LATCH_G}, 32'd0);
    chk("rc_done_mid", {31'b0, DONE}, 32'd0);
    step();
    chk("rc_latch3", {31'b0, LATCH_G}, 32'd1);
    chk("rc_done", {31'b0, DONE}, 32'd0);
    chk("rc_busy", {31'b0, BUSY}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cfg_frame_loader.md
# cfg_frame_loader

Configuration frame loader for the programmable fabric. It accepts a configuration frame as a stream of words over a valid/ready handshake and verifies an XOR checksum. It assembles the frame in a shadow register whose bits drive the SEL inputs of the routing MUX cells through a bank of HOLD_LATCH cells. On a good frame it pulses the shared latch gate low so the latches capture the new configuration atomically; on a bad or aborted frame the latches are never opened.

## Interface
- WORD_W, 8, input word width; also the checksum width.
- FRAME_BITS, 64, configuration bits per frame; must be a multiple of WORD_W.
- LATCH_CYCLES, 2, cycles LATCH_G is held low per commit; must be ≥1.
- Derived: NWORDS = FRAME_BITS/WORD_W; word counter width = clog2(NWORDS+1).
- CLK  in  1  clock.
- RESET  in  1  reset, synchronous, active-high.
- START  in  1  begin a frame load; honoured only in IDLE.
- ABORT  in  1  abandon the current load; honoured only in LOAD.
- IN_DATA  in  WORD_W  frame word or checksum word.
- IN_VALID  in  1  IN_DATA valid.
- IN_READY  out  1  loader accepts a word; a transfer occurs when IN_VALID&IN_READY.
- CFG_OUT  out  FRAME_BITS  shadow register, wired to the latch D inputs.
- LATCH_G  out  1  latch gate; 0 = latches transparent, 1 = hold.
- BUSY  out  1  state != IDLE.
- DONE  out  1  one-cycle pulse when a commit completes.
- ERR  out  1  sticky checksum-error flag.

## Operation
- States:
  - IDLE: IN_READY=0, LATCH_G=1.
  - LOAD: IN_READY=1, LATCH_G=1.
  - COMMIT: IN_READY=0, LATCH_G=0.
- IDLE → LOAD on START. Entering LOAD clears the word counter, the checksum accumulator and ERR. The shadow register is not cleared.
- LOAD, data transfers (counter < NWORDS):
  - shadow <= {IN_DATA, shadow[FRAME_BITS-1:WORD_W]};
  - acc <= acc ^ IN_DATA;
  - counter increments.
  - After NWORDS transfers, the first word sits in CFG_OUT[WORD_W-1:0].
- LOAD, checksum transfer (counter == NWORDS):
  - IN_DATA == acc → COMMIT, with the commit counter loaded to LATCH_CYCLES.
  - IN_DATA != acc → IDLE with ERR set. LATCH_G stays 1 and DONE stays 0.
- ABORT in LOAD → IDLE immediately. A transfer presented in the same cycle is dropped. No DONE, ERR unchanged, shadow left partially shifted.
- ABORT outside LOAD is ignored; a commit cannot be torn.
- START outside IDLE is ignored.
- COMMIT: LATCH_G=0 for exactly LATCH_CYCLES cycles, then IDLE.
  - CFG_OUT is stable throughout COMMIT.
  - DONE=1 in the first IDLE cycle after a normal commit.
- Reset commit:
  - RESET high → shadow=0, counter=0, acc=0, ERR=0, state=COMMIT with the commit counter at LATCH_CYCLES. LATCH_G=0 while RESET is high.
  - After RESET falls, the reset commit runs LATCH_CYCLES more cycles, then IDLE.
  - DONE is never pulsed for a reset commit. This forces all routing latches to 0 after every reset.
- Checksum arithmetic is a plain XOR over WORD_W bits. No carries, no width growth.

## Timing
- START sampled at cycle 0 → LOAD and IN_READY=1 at cycle 1.
- Minimum frame duration: NWORDS+1 transfer cycles.
- Checksum transfer at cycle t:
  - LATCH_G=0 during t+1 .. t+LATCH_CYCLES.
  - State=IDLE and DONE=1 at t+LATCH_CYCLES+1.
  - BUSY falls at t+LATCH_CYCLES+1.
- Checksum mismatch at cycle t → ERR=1 and BUSY=0 at t+1.
- IN_READY, LATCH_G, BUSY and DONE decode directly from registered state; there is no combinational path from IN_VALID.
- Idle cycles with IN_VALID=0 during LOAD are allowed in any number; the counter holds.
- RESET overrides every other input in the same cycle, including mid-LOAD and mid-COMMIT.

## Test plan
(All scenarios use WORD_W=8, FRAME_BITS=32, LATCH_CYCLES=2.)
- **Reset:** RESET high 3 cycles → CFG_OUT=0x00000000, LATCH_G=0 during reset and 2 cycles after, then 1. BUSY=0 afterwards; DONE and ERR stay 0.
- **Good frame:** START, then 0x11, 0x22, 0x33, 0x44, checksum 0x44 back-to-back → CFG_OUT=0x44332211. LATCH_G low exactly 2 cycles starting the cycle after the checksum, DONE high 1 cycle at +3, ERR=0.
- **Bad checksum:** same data with checksum 0x45 → ERR=1 at +1, LATCH_G never low, DONE=0, IN_READY=0. Next START clears ERR.
- **Bubbles and handshake:** IN_VALID asserted every other cycle; words presented in IDLE are not accepted (IN_READY=0) → identical result to the good frame. A START pulse during LOAD does not restart the counter.
- **Abort:** ABORT after 2 words → IDLE next cycle, no DONE, ERR unchanged, LATCH_G=1. A following good frame 0xAA, 0xBB, 0xCC, 0xDD, checksum 0x00 commits CFG_OUT=0xDDCCBBAA.
- **Reset mid-operation:** RESET during LOAD (after 3 words) and, separately, during COMMIT cycle 1 → CFG_OUT=0, the reset commit holds LATCH_G low until 2 cycles after RESET falls, and no DONE pulse.
